// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (open-drain clock/data)
// Optional PS2_TX_RETRY_EN: resend a NACKed byte up to two more times before ack_err.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_RELEASE, S_SHIFT, S_WAIT_IDLE
  } state_t;

  state_t        r_state, w_state_next;
  logic [1:0]    r_scl_sync, r_sda_sync;
  logic          r_scl_prev;
  logic [7:0]    r_data;
  logic          r_parity;
  logic [3:0]    r_bit, w_bit_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [1:0]    r_retry, w_retry_next;
  logic          w_scl, w_sda, w_fall, w_accept, w_to_hit, w_data_bit;

  assign w_scl      = r_scl_sync[1];
  assign w_sda      = r_sda_sync[1];
  assign w_fall     = r_scl_prev & ~w_scl;
  assign tx_ready   = (r_state == S_IDLE);
  assign busy       = ~tx_ready;
  assign w_accept   = tx_valid & tx_ready;
  assign w_data_bit = r_data[3'(r_bit - 4'd1)];
  // The timeout window runs from clock release until the bus returns idle after ACK.
  assign w_to_hit   = ((r_state == S_RELEASE) || (r_state == S_SHIFT) ||
                       (r_state == S_WAIT_IDLE)) && (r_cnt == TO_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_prev <= 1'b1;
      r_data     <= '0;
      r_parity   <= 1'b0;
      r_bit      <= '0;
      r_cnt      <= '0;
      r_retry    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_scl_sync <= {r_scl_sync[0], scl_in};
      r_sda_sync <= {r_sda_sync[0], sda_in};
      r_scl_prev <= w_scl;
      r_bit      <= w_bit_next;
      r_cnt      <= w_cnt_next;
      r_retry    <= w_retry_next;
      if (w_accept) begin
        r_data   <= tx_data;
        r_parity <= ~^tx_data;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_bit_next   = r_bit;
    w_cnt_next   = r_cnt;
    w_retry_next = r_retry;
    scl_oe       = 1'b0;
    sda_oe       = 1'b0;
    done         = 1'b0;
    ack_err      = 1'b0;
    timeout      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_INHIBIT;
          w_cnt_next   = '0;
          w_retry_next = '0;
        end
      end
      S_INHIBIT: begin
        scl_oe = 1'b1;
        if (r_cnt == INH_LAST) begin
          w_state_next = S_REQ;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_REQ: begin
        scl_oe       = 1'b1;
        sda_oe       = 1'b1;
        w_state_next = S_RELEASE;
        w_cnt_next   = '0;
        w_bit_next   = '0;
      end
      S_RELEASE: begin
        sda_oe     = 1'b1;
        w_cnt_next = r_cnt + 1'b1;
        if (w_fall) begin
          w_state_next = S_SHIFT;
          w_bit_next   = 4'd1;
        end
      end
      S_SHIFT: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_bit <= 4'd8) begin
          sda_oe = ~w_data_bit;
        end else if (r_bit == 4'd9) begin
          sda_oe = ~r_parity;
        end
        if (w_fall) begin
          if (r_bit == 4'd10) begin
            if (!w_sda) begin
              w_state_next = S_WAIT_IDLE;
            end else begin
`ifdef PS2_TX_RETRY_EN
              if (r_retry != 2'd2) begin
                w_retry_next = r_retry + 2'd1;
                w_state_next = S_INHIBIT;
                w_cnt_next   = '0;
              end else begin
                ack_err      = 1'b1;
                w_state_next = S_IDLE;
              end
`else
              ack_err      = 1'b1;
              w_state_next = S_IDLE;
`endif
            end
          end else begin
            w_bit_next = r_bit + 4'd1;
          end
        end
      end
      S_WAIT_IDLE: begin
        w_cnt_next = r_cnt + 1'b1;
        if (w_scl && w_sda) begin
          done         = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    // Timeout overrides any bit activity in the same cycle and lets go of the bus at once.
    if (w_to_hit) begin
      w_state_next = S_IDLE;
      w_retry_next = r_retry;
      scl_oe       = 1'b0;
      sda_oe       = 1'b0;
      done         = 1'b0;
      ack_err      = 1'b0;
      timeout      = 1'b1;
    end
    if (rst) begin
      done    = 1'b0;
      ack_err = 1'b0;
      timeout = 1'b0;
    end
  end
endmodule
